// File: rtl/regfile_writeback_queue_pkg.sv
// Shared definitions for the register-file writeback queue and its users.
//   AW_DEF / DW_DEF : default register address / data widths of the 32x32 file
//   ZERO_REG        : register that is hardwired to zero (writes are discarded)
//   is_zero_reg()   : helper that compares an address against ZERO_REG
package regfile_writeback_queue_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    localparam logic [4:0] ZERO_REG = 5'd31;

    function automatic logic is_zero_reg(input logic [4:0] addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Writeback request channel plus register-file write port.
//   wb_valid/wb_ready/wb_addr/wb_data : request channel (producer -> queue)
//   rf_hold                           : register file busy (file -> queue)
//   rf_D/rf_DA/rf_W                   : write port (queue -> file)
//
// Handshake: a request transfers on a rising edge where wb_valid && wb_ready.
// The producer holds wb_addr/wb_data stable while wb_valid is high and the
// transfer has not happened; wb_ready depends only on registered state and
// never on wb_valid in the same cycle.
interface regfile_writeback_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rf_hold;
    logic [DW-1:0] rf_D;
    logic [AW-1:0] rf_DA;
    logic          rf_W;

    // Environment side: issues requests, models the register file.
    modport master (
        output wb_valid, wb_addr, wb_data, rf_hold,
        input  wb_ready, rf_D, rf_DA, rf_W
    );

    // Queue side.
    modport slave (
        input  wb_valid, wb_addr, wb_data, rf_hold,
        output wb_ready, rf_D, rf_DA, rf_W
    );
endinterface

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the queue entries for one read select.
//   ent_valid/ent_addr/ent_data : queue storage (indexed by slot)
//   head                        : slot of the oldest entry
//   sel                         : read select to match
//   hit/data                    : youngest matching entry, or 0/0
module wbq_fwd_match
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic [DEPTH-1:0]         ent_valid,
    input  logic [DEPTH-1:0][AW-1:0] ent_addr,
    input  logic [DEPTH-1:0][DW-1:0] ent_data,
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [AW-1:0]            sel,
    output logic                     hit,
    output logic [DW-1:0]            data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from oldest (head) to youngest; a later match overrides an
    // earlier one, so the last one standing is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (ent_valid[idx] && (ent_addr[idx] == sel) && (sel != AW'(ZERO_REG))) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue in front of the 32x32 register-file write port.
//   clock, reset       : clock and synchronous active-high reset
//   bus (slave)        : writeback request channel and rf_D/rf_DA/rf_W port
//   SA, SB             : register-file read selects
//   fwd_A_*, fwd_B_*   : youngest queued write to SA / SB
//   count              : occupied entries (0..DEPTH)
// Writes to ZERO_REG complete the handshake but are never stored.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    regfile_writeback_queue_if.slave bus,
    input  logic [AW-1:0]          SA,
    input  logic [AW-1:0]          SB,
    output logic                   fwd_A_hit,
    output logic [DW-1:0]          fwd_A_data,
    output logic                   fwd_B_hit,
    output logic [DW-1:0]          fwd_B_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count_q;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;

    logic empty;
    logic full;
    logic accept;
    logic enq;
    logic pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign accept = bus.wb_valid && bus.wb_ready;
    assign enq    = accept && (bus.wb_addr != AW'(ZERO_REG));
    assign pop    = bus.rf_W;

    assign bus.wb_ready = !full;
    // Reset gates the write enable so a reset cycle never commits a write.
    assign bus.rf_W     = !reset && !empty && !bus.rf_hold;
    assign bus.rf_D     = empty ? '0 : ent_data[head];
    assign bus.rf_DA    = empty ? '0 : ent_addr[head];
    assign count        = count_q;

    // Pointers, occupancy and valid bits. Enqueue and pop never touch the
    // same slot: tail == head only when empty (no pop) or full (no enqueue).
    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            ent_valid <= '0;
        end else begin
            if (enq) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            count_q <= count_q + CW'(enq) - CW'(pop);
        end
    end

    // Payload storage needs no reset; it is qualified by ent_valid/count.
    always_ff @(posedge clock) begin
        if (!reset && enq) begin
            ent_addr[tail] <= bus.wb_addr;
            ent_data[tail] <= bus.wb_data;
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .head      (head),
        .sel       (SA),
        .hit       (fwd_A_hit),
        .data      (fwd_A_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .head      (head),
        .sel       (SB),
        .hit       (fwd_B_hit),
        .data      (fwd_B_data)
    );
endmodule
